rr_reg_arbiter: RTL and testbench

Round-robin arbiter that shares one DATA_W-bit positive-edge register with asynchronous active-low clear among NUM_REQ requesters. It grants write access one requester at a time and captures the winner's data into the shared register. It enforces a programmable hold-off between writes. It sits between independent producer blocks and a single shared state register.

---
 rtl/rr_reg_arbiter.sv | 74 +++++++
 tb/tb_rr_reg_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_reg_arbiter.sv
// rr_reg_arbiter: round-robin write arbiter for one shared register with post-write hold-off
module rr_reg_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W = 8,
    parameter int HOLD_CYC = 2,
    localparam int OWNER_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] wr_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [DATA_W-1:0]         q,
    output logic [DATA_W-1:0]         q_not,
    output logic [OWNER_W-1:0]        owner,
    output logic                      valid,
    output logic                      busy
);
    localparam int CNT_W = HOLD_CYC > 1 ? $clog2(HOLD_CYC) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

    state_t             state;
    logic [OWNER_W-1:0] ptr, sel, pick, sel_next;
    logic [CNT_W-1:0]   cnt;

    // downward scan so the requester closest to ptr wins
    always_comb begin
        pick = ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req[(int'(ptr) + i) % NUM_REQ]) pick = OWNER_W'((int'(ptr) + i) % NUM_REQ);
    end

    assign sel_next = OWNER_W'((int'(sel) + 1) % NUM_REQ);
    assign gnt      = (state == GRANT && req[sel]) ? NUM_REQ'(1) << sel : '0;
    assign busy     = state != IDLE;
    assign q_not    = ~q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ptr   <= '0;
            sel   <= '0;
            cnt   <= '0;
            q     <= '0;
            owner <= '0;
            valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        sel   <= pick;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (req[sel]) begin
                        q     <= wr_data[sel*DATA_W +: DATA_W];
                        owner <= sel;
                        valid <= 1'b1;
                        ptr   <= sel_next;
                    end
                    cnt   <= '0;
                    state <= (req[sel] && HOLD_CYC > 0) ? HOLD : IDLE;
                end
                HOLD: begin
                    cnt <= cnt + 1'b1;
                    if (int'(cnt) >= HOLD_CYC - 1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rr_reg_arbiter.sv
// tb_rr_reg_arbiter: directed and random checks of rr_reg_arbiter against a grant/hold reference model
module tb_rr_reg_arbiter;
    localparam int N = 4, W = 8, HOLD = 2;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N*W-1:0] wr_data = '0;
    logic [N-1:0] gnt;
    logic [W-1:0] q, q_not;
    logic [1:0]   owner;
    logic         valid, busy;

    rr_reg_arbiter #(.NUM_REQ(N), .DATA_W(W), .HOLD_CYC(HOLD)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .wr_data(wr_data),
        .gnt(gnt), .q(q), .q_not(q_not), .owner(owner), .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc_n = 0;
    int m_ptr, m_sel, m_hold, m_owner;
    logic [W-1:0] m_q;
    logic m_valid;

    function automatic void mreset();
        m_ptr = 0; m_sel = -1; m_hold = 0; m_owner = 0; m_q = '0; m_valid = 1'b0;
    endfunction

    // one clock edge of the reference: pending winner writes, hold counts down, else arbitrate
    function automatic void model_edge();
        if (!reset_n) begin
            mreset();
            return;
        end
        if (m_sel >= 0) begin
            if (req[m_sel]) begin
                m_q = wr_data[m_sel*W +: W];
                m_owner = m_sel;
                m_valid = 1'b1;
                m_ptr = (m_sel + 1) % N;
                m_hold = HOLD;
            end
            m_sel = -1;
        end else if (m_hold > 0) begin
            m_hold--;
        end else begin
            for (int i = 0; i < N; i++)
                if (req[(m_ptr + i) % N]) begin
                    m_sel = (m_ptr + i) % N;
                    break;
                end
        end
    endfunction

    function automatic logic [N-1:0] exp_gnt();
        return (m_sel >= 0 && req[m_sel]) ? N'(1) << m_sel : '0;
    endfunction

    task automatic cmp(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk(string tag);
        logic [W-1:0] qn;
        qn = ~m_q;
        cmp({tag, ":gnt"}, 32'(gnt), 32'(exp_gnt()));
        cmp({tag, ":busy"}, 32'(busy), 32'(m_sel >= 0 || m_hold > 0));
        cmp({tag, ":q"}, 32'(q), 32'(m_q));
        cmp({tag, ":q_not"}, 32'(q_not), 32'(qn));
        cmp({tag, ":owner"}, 32'(owner), 32'(m_owner));
        cmp({tag, ":valid"}, 32'(valid), 32'(m_valid));
    endtask

    task automatic cyc(string tag);
        @(posedge clk);
        model_edge();
        cyc_n++;
        #1;
        chk(tag);
    endtask

    task automatic wait_grant(string tag, output int idx);
        idx = -1;
        for (int k = 0; k < 20 && idx < 0; k++) begin
            cyc(tag);
            for (int i = 0; i < N; i++) if (gnt[i]) idx = i;
        end
        if (idx < 0) begin
            total++;
            bad++;
            $error("FAIL %s:timeout got=no_grant exp=grant", tag);
        end
    endtask

    task automatic set_data(int i, logic [W-1:0] d);
        wr_data[i*W +: W] = d;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        mreset();
        req = '0;
        repeat (2) cyc("rst");
        reset_n = 1'b1;
    endtask

    initial begin
        int idx;
        int g[5];
        int at[5];
        logic [W-1:0] d0;
        logic [N-1:0] prev_g;
        mreset();
        wr_data = 32'($urandom);
        // reset held with all requests up
        req = 4'hF;
        repeat (3) cyc("t1");
        cmp("t1:q", 32'(q), 32'h00);
        cmp("t1:q_not", 32'(q_not), 32'hFF);
        cmp("t1:gnt", 32'(gnt), 0);
        cmp("t1:busy", 32'(busy), 0);
        cmp("t1:valid", 32'(valid), 0);
        cmp("t1:owner", 32'(owner), 0);
        // single request
        reset_n = 1'b1;
        set_data(2, 8'hA5);
        req = 4'b0100;
        wait_grant("t2", idx);
        cmp("t2:idx", 32'(idx), 2);
        cmp("t2:gnt", 32'(gnt), 32'h4);
        cyc("t2");
        req = '0;
        cmp("t2:q", 32'(q), 32'hA5);
        cmp("t2:q_not", 32'(q_not), 32'h5A);
        cmp("t2:owner", 32'(owner), 2);
        cmp("t2:valid", 32'(valid), 1);
        cmp("t2:gnt_off", 32'(gnt), 0);
        cmp("t2:busy1", 32'(busy), 1);
        cyc("t2");
        cmp("t2:busy2", 32'(busy), 1);
        cyc("t2");
        cmp("t2:busy3", 32'(busy), 0);
        // continuous round robin
        do_reset();
        req = 4'hF;
        for (int j = 0; j < 5; j++) begin
            wait_grant("t3", idx);
            g[j] = idx;
            at[j] = cyc_n;
        end
        for (int j = 0; j < 5; j++) cmp("t3:order", 32'(g[j]), 32'(j % 4));
        for (int j = 1; j < 5; j++) cmp("t3:gap", 32'(at[j] - at[j-1]), 4);
        cyc("t3");
        req = '0;
        repeat (3) cyc("t3");
        // pointer wrap after grant to 3
        req = 4'b1000;
        wait_grant("t4", idx);
        cmp("t4:first3", 32'(idx), 3);
        cyc("t4");
        req = 4'b1001;
        wait_grant("t4", idx);
        cmp("t4:then0", 32'(idx), 0);
        cyc("t4");
        req = 4'b1000;
        wait_grant("t4", idx);
        cmp("t4:then3", 32'(idx), 3);
        cyc("t4");
        req = '0;
        repeat (3) cyc("t4");
        // asynchronous reset in the middle of a grant
        req = 4'b0010;
        wait_grant("t5", idx);
        cmp("t5:gnt1", 32'(gnt), 32'h2);
        #2 reset_n = 1'b0;
        #1;
        mreset();
        chk("t5");
        cmp("t5:gnt_async", 32'(gnt), 0);
        cmp("t5:busy_async", 32'(busy), 0);
        cmp("t5:q_async", 32'(q), 0);
        req = '0;
        cyc("t5");
        reset_n = 1'b1;
        d0 = 8'h3C;
        set_data(0, d0);
        req = 4'b0011;
        wait_grant("t5", idx);
        cmp("t5:after0", 32'(idx), 0);
        cyc("t5");
        req = 4'b0010;
        // requester 1 withdraws during its own grant cycle
        for (int k = 0; k < 10 && m_sel != 1; k++) cyc("t6");
        cmp("t6:reached", 32'(m_sel), 1);
        req = '0;
        #1;
        chk("t6");
        cmp("t6:gnt0", 32'(gnt), 0);
        cyc("t6");
        cmp("t6:busy", 32'(busy), 0);
        cmp("t6:owner", 32'(owner), 0);
        cmp("t6:q", 32'(q), 32'(d0));
        req = 4'b0010;
        wait_grant("t6", idx);
        cmp("t6:ptr_kept", 32'(idx), 1);
        cyc("t6");
        req = '0;
        // random traffic with occasional protocol violations and resets
        prev_g = '0;
        for (int r = 0; r < 400; r++) begin
            cyc("rnd");
            if (!reset_n) reset_n = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (prev_g[i] && $urandom_range(0, 9) < 6) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    set_data(i, 8'($urandom));
                end
            end
            prev_g = gnt;
            if (gnt != '0 && $urandom_range(0, 49) == 0) begin
                req = req & ~gnt;
                prev_g = '0;
                #1 chk("rnd_viol");
            end
            if ($urandom_range(0, 99) == 0) begin
                #2 reset_n = 1'b0;
                #1;
                mreset();
                prev_g = '0;
                chk("rnd_rst");
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
